// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and counter sizing.
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/cla_adder_n.sv
// N-bit adder built from chained 4-bit carry-lookahead slices.
// Each slice resolves its four internal carries in parallel from its carry-in.
module cla_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    genvar k;
    generate
        for (k = 0; k < N / 4; k++) begin : g_slice
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] cc;
            logic       ci;
            logic       co;

            if (k == 0) begin : g_first
                assign ci = cin;
            end else begin : g_rest
                assign ci = g_slice[k-1].co;
            end

            assign g     = x[4*k +: 4] & y[4*k +: 4];
            assign p     = x[4*k +: 4] ^ y[4*k +: 4];
            assign cc[0] = ci;
            assign cc[1] = g[0] | (p[0] & ci);
            assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                         | (p[2] & p[1] & p[0] & ci);
            assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                         | (p[3] & p[2] & p[1] & g[0])
                         | (p[3] & p[2] & p[1] & p[0] & ci);
            assign co    = cc[4];
            assign s[4*k +: 4] = p ^ cc[3:0];
        end
    endgenerate

    assign cout = g_slice[N/4-1].co;

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier (MULT/MULTU into HI/LO): magnitudes are
// multiplied unsigned over WIDTH RUN cycles, then the product sign is fixed in SIGN.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_neg, b_neg, addend, sum;
    logic               a_neg_co, b_neg_co, sum_co;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic               prod_neg_co;
    logic               load;

    assign addend = mq_q[0] ? mcand_q : {WIDTH{1'b0}};
    assign prod   = {acc_q, mq_q};
    assign load   = start & ((state_q == IDLE) | (state_q == DONE));

    cla_adder_n #(.N(WIDTH)) u_neg_a (
        .x(~a), .y({WIDTH{1'b0}}), .cin(1'b1), .s(a_neg), .cout(a_neg_co)
    );

    cla_adder_n #(.N(WIDTH)) u_neg_b (
        .x(~b), .y({WIDTH{1'b0}}), .cin(1'b1), .s(b_neg), .cout(b_neg_co)
    );

    cla_adder_n #(.N(WIDTH)) u_acc (
        .x(acc_q), .y(addend), .cin(1'b0), .s(sum), .cout(sum_co)
    );

    cla_adder_n #(.N(2*WIDTH)) u_neg_p (
        .x(~prod), .y({(2*WIDTH){1'b0}}), .cin(1'b1), .s(prod_neg), .cout(prod_neg_co)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mq_d    = mq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = {sum_co, sum[WIDTH-1:1]};
                mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = SIGN;
                end else begin
                    state_d = RUN;
                end
            end
            SIGN: begin
                // A zero product carries out of its negation and stays zero.
                if (neg_q && !prod_neg_co) begin
                    {hi_d, lo_d} = prod_neg;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            mcand_d = (is_signed && a[WIDTH-1] && !a_neg_co) ? a_neg : a;
            mq_d    = (is_signed && b[WIDTH-1] && !b_neg_co) ? b_neg : b;
            acc_d   = {WIDTH{1'b0}};
            cnt_d   = CW'(WIDTH - 1);
            neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
            neg_d = neg_q;
        end

        busy_d = (state_d == RUN) || (state_d == SIGN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= {WIDTH{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            mq_q    <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: expected products are queued at issue and
// compared (value and latency) whenever done pulses.
module tb_mult_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        logic [63:0] xe, ye;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic s, input int c);
        exp_t        e;
        logic [63:0] p;
        p     = model(x, y, s);
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.cyc = c;
        return e;
    endfunction

    // Drive one request; returns #1 after the edge that samples start.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit track);
        @(negedge clk);
        start     = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) sb.push_back(make_exp(x, y, s, cyc));
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            check("done_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("latency", 64'(cyc - e.cyc), 64'd33);
            end
        end
    end

    logic [W-1:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
    logic [W-1:0] vb [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003,
                             32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0001};
    logic         vs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int bc, t;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 3 x 5 with busy-duration count.
        issue(32'd3, 32'd5, 1'b0, 1'b1);
        check("busy_after_start", 64'(busy), 64'd1);
        bc = 1;
        t  = 0;
        while (done !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) bc++;
            t++;
        end
        check("busy_cycles", 64'(bc), 64'd33);
        wait_empty();
        repeat (5) @(posedge clk);
        #1;
        check("lo_hold", 64'(lo), 64'd15);
        check("hi_hold", 64'(hi), 64'd0);
        check("done_low_idle", 64'(done), 64'd0);

        // Directed corner cases, then a few random operands.
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], vs[i], 1'b1);
            wait_empty();
        end
        for (int i = 0; i < 6; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1'b1);
            wait_empty();
        end

        // Starts during RUN are ignored; start in the DONE cycle chains a new op.
        issue(32'd3, 32'd5, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        start     = 1'b1;
        a         = 32'd100;
        b         = 32'd100;
        is_signed = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            @(negedge clk);
            a = a + 32'd1;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_run", 64'(busy), 64'd1);
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(done), 64'd1);
        start     = 1'b1;
        a         = 32'd6;
        b         = 32'd7;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(make_exp(32'd6, 32'd7, 1'b0, cyc));
        check("busy_b2b", 64'(busy), 64'd1);
        wait_empty();

        // Reset in the middle of a run discards it.
        issue(32'd3, 32'd5, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_lo_quiet", 64'(lo), 64'd0);
        issue(32'd2, 32'd2, 1'b0, 1'b1);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
